// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Tracks destination register and remaining result latency (tnew) of the
// instructions in E, M and W. From that state it derives the operand
// forwarding selects for D, E and M and the load-use stall. A saturating
// counter records how many cycles the pipeline spent stalled.
//
// Every output is combinational from the stage registers plus the D-stage
// inputs; there is no output register.

module fwd_sel_ctrl #(
   parameter int RegBits = 5,
   parameter int CntBits = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [RegBits-1:0] d_rs,
   input  logic [RegBits-1:0] d_rt,
   input  logic [1:0]         d_tuse_rs,
   input  logic [1:0]         d_tuse_rt,
   input  logic [RegBits-1:0] d_dst,
   input  logic [1:0]         d_tnew,
   output logic               stall,
   output logic [1:0]         fwd_d_rs_sel,
   output logic [1:0]         fwd_d_rt_sel,
   output logic [1:0]         fwd_e_rs_sel,
   output logic [1:0]         fwd_e_rt_sel,
   output logic               fwd_m_rt_sel,
   output logic [CntBits-1:0] stall_cnt
);

   // tuse code meaning "operand not read"; such an operand never stalls
   localparam logic [1:0] TuseNone = 2'd3;

   // D-stage select encodings
   localparam logic [1:0] DSelRf = 2'b00;
   localparam logic [1:0] DSelE  = 2'b01;
   localparam logic [1:0] DSelM  = 2'b10;
   localparam logic [1:0] DSelW  = 2'b11;

   // E-stage select encodings
   localparam logic [1:0] ESelPipe = 2'b00;
   localparam logic [1:0] ESelM    = 2'b01;
   localparam logic [1:0] ESelW    = 2'b10;

   // ------------------------------------------------------------------
   // Stage registers. A stage whose dst is 0 is a bubble: register $0 is
   // never written, so it can never match a nonzero source.
   // ------------------------------------------------------------------
   logic [RegBits-1:0] e_rs_reg;
   logic [RegBits-1:0] e_rt_reg;
   logic [RegBits-1:0] e_dst_reg;
   logic [1:0]         e_tnew_reg;
   logic [RegBits-1:0] m_rt_reg;
   logic [RegBits-1:0] m_dst_reg;
   logic [1:0]         m_tnew_reg;
   logic [RegBits-1:0] w_dst_reg;
   logic [CntBits-1:0] stall_cnt_reg;

   logic [1:0]         m_tnew_next;
   logic               stall_cnt_sat;

   // Per-source vectors, index 0 = rs, index 1 = rt
   logic [2*RegBits-1:0] d_src_flat;
   logic [3:0]           d_tuse_flat;
   logic [2*RegBits-1:0] e_src_flat;
   logic [1:0]           conflict_vec;
   logic [3:0]           d_sel_flat;
   logic [3:0]           e_sel_flat;

   assign d_src_flat  = {d_rt, d_rs};
   assign d_tuse_flat = {d_tuse_rt, d_tuse_rs};
   assign e_src_flat  = {e_rt_reg, e_rs_reg};

   // ------------------------------------------------------------------
   // D-stage hazard detection and D-stage forwarding, one copy per source
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_d_src
         logic [RegBits-1:0] src;
         logic [1:0]         tuse;
         logic               src_nz;
         logic               hit_e;
         logic               hit_m;
         logic               hit_w;
         logic               conflict;
         logic [1:0]         sel;

         assign src    = d_src_flat[gi*RegBits +: RegBits];
         assign tuse   = d_tuse_flat[gi*2 +: 2];
         assign src_nz = |src;
         assign hit_e  = src_nz && (e_dst_reg == src);
         assign hit_m  = src_nz && (m_dst_reg == src);
         assign hit_w  = src_nz && (w_dst_reg == src);

         // Stall when the operand is needed before a producer in E or M
         // can deliver it; a producer in W is always ready.
         always_comb begin
            conflict = 1'b0;
            if (src_nz && (tuse != TuseNone)) begin
               if (hit_e && (tuse < e_tnew_reg)) begin
                  conflict = 1'b1;
               end
               if (hit_m && (tuse < m_tnew_reg)) begin
                  conflict = 1'b1;
               end
            end
         end

         // D compare source: youngest ready producer wins (E > M > W)
         always_comb begin
            sel = DSelRf;
            if (hit_e && (e_tnew_reg == 2'd0)) begin
               sel = DSelE;
            end else if (hit_m && (m_tnew_reg == 2'd0)) begin
               sel = DSelM;
            end else if (hit_w) begin
               sel = DSelW;
            end
         end

         assign conflict_vec[gi]       = conflict;
         assign d_sel_flat[gi*2 +: 2]  = sel;
      end
   endgenerate

   // ------------------------------------------------------------------
   // E-stage operand forwarding, one copy per source
   // ------------------------------------------------------------------
   generate
      for (gi = 0; gi < 2; gi++) begin : g_e_src
         logic [RegBits-1:0] src;
         logic               src_nz;
         logic [1:0]         sel;

         assign src    = e_src_flat[gi*RegBits +: RegBits];
         assign src_nz = |src;

         // E operand source: M result if already computed, else W
         always_comb begin
            sel = ESelPipe;
            if (src_nz && (m_dst_reg == src) && (m_tnew_reg == 2'd0)) begin
               sel = ESelM;
            end else if (src_nz && (w_dst_reg == src)) begin
               sel = ESelW;
            end
         end

         assign e_sel_flat[gi*2 +: 2] = sel;
      end
   endgenerate

   assign stall        = |conflict_vec;
   assign fwd_d_rs_sel = d_sel_flat[1:0];
   assign fwd_d_rt_sel = d_sel_flat[3:2];
   assign fwd_e_rs_sel = e_sel_flat[1:0];
   assign fwd_e_rt_sel = e_sel_flat[3:2];

   // M store data comes from W when W is writing the store's rt
   assign fwd_m_rt_sel = (|m_rt_reg) && (w_dst_reg == m_rt_reg);

   assign stall_cnt     = stall_cnt_reg;
   assign stall_cnt_sat = &stall_cnt_reg;

   // Remaining latency decreases by one per stage, clamped at zero
   always_comb begin
      m_tnew_next = 2'd0;
      if (e_tnew_reg != 2'd0) begin
         m_tnew_next = e_tnew_reg - 2'd1;
      end
   end

   // E stage: take the D instruction, or a bubble while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_rs_reg   <= '0;
         e_rt_reg   <= '0;
         e_dst_reg  <= '0;
         e_tnew_reg <= '0;
      end else if (stall) begin
         e_rs_reg   <= '0;
         e_rt_reg   <= '0;
         e_dst_reg  <= '0;
         e_tnew_reg <= '0;
      end else begin
         e_rs_reg   <= d_rs;
         e_rt_reg   <= d_rt;
         e_dst_reg  <= d_dst;
         e_tnew_reg <= d_tnew;
      end
   end

   // M and W stages advance unconditionally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rt_reg   <= '0;
         m_dst_reg  <= '0;
         m_tnew_reg <= '0;
         w_dst_reg  <= '0;
      end else begin
         m_rt_reg   <= e_rt_reg;
         m_dst_reg  <= e_dst_reg;
         m_tnew_reg <= m_tnew_next;
         w_dst_reg  <= m_dst_reg;
      end
   end

   // Count stalled cycles, holding at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_reg <= '0;
      end else if (stall && !stall_cnt_sat) begin
         stall_cnt_reg <= stall_cnt_reg + CntBits'(1);
      end
   end

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Directed bench for fwd_sel_ctrl. Uses a 3-bit stall counter so that
// saturation is reached by real stalls.

module tb_fwd_sel_ctrl;

   localparam int RegBits = 5;
   localparam int CntBits = 3;

   logic               clk;
   logic               rst_n;
   logic [RegBits-1:0] d_rs;
   logic [RegBits-1:0] d_rt;
   logic [1:0]         d_tuse_rs;
   logic [1:0]         d_tuse_rt;
   logic [RegBits-1:0] d_dst;
   logic [1:0]         d_tnew;
   logic               stall;
   logic [1:0]         fwd_d_rs_sel;
   logic [1:0]         fwd_d_rt_sel;
   logic [1:0]         fwd_e_rs_sel;
   logic [1:0]         fwd_e_rt_sel;
   logic               fwd_m_rt_sel;
   logic [CntBits-1:0] stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   fwd_sel_ctrl #(
      .RegBits (RegBits),
      .CntBits (CntBits)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .d_rs         (d_rs),
      .d_rt         (d_rt),
      .d_tuse_rs    (d_tuse_rs),
      .d_tuse_rt    (d_tuse_rt),
      .d_dst        (d_dst),
      .d_tnew       (d_tnew),
      .stall        (stall),
      .fwd_d_rs_sel (fwd_d_rs_sel),
      .fwd_d_rt_sel (fwd_d_rt_sel),
      .fwd_e_rs_sel (fwd_e_rs_sel),
      .fwd_e_rt_sel (fwd_e_rt_sel),
      .fwd_m_rt_sel (fwd_m_rt_sel),
      .stall_cnt    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Drive the D-stage instruction
   task automatic set_d(input logic [4:0] rs, input logic [1:0] tu_rs,
                        input logic [4:0] rt, input logic [1:0] tu_rt,
                        input logic [4:0] dst, input logic [1:0] tnew);
      d_rs      = rs;
      d_tuse_rs = tu_rs;
      d_rt      = rt;
      d_tuse_rt = tu_rt;
      d_dst     = dst;
      d_tnew    = tnew;
      #1;
   endtask

   task automatic set_idle();
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---------------- reset with random D inputs ----------------
      rst_n = 1'b0;
      set_d(5'($urandom), 2'($urandom), 5'($urandom), 2'($urandom),
            5'($urandom), 2'($urandom_range(0, 2)));
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_dsel", 32'({fwd_d_rs_sel, fwd_d_rt_sel}), 32'd0);
      chk("rst_esel", 32'({fwd_e_rs_sel, fwd_e_rt_sel, fwd_m_rt_sel}), 32'd0);
      chk("rst_cnt", 32'(stall_cnt), 32'd0);
      tick();
      set_d(5'd7, 2'd0, 5'd7, 2'd0, 5'd7, 2'd2);
      chk("rst_hold_stall", 32'(stall), 32'd0);
      chk("rst_hold_cnt", 32'(stall_cnt), 32'd0);
      set_idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---------------- ALU -> ALU ----------------
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 2'd1);
      chk("alu_w_stall", 32'(stall), 32'd0);
      tick();
      set_d(5'd5, 2'd1, 5'd0, 2'd3, 5'd0, 2'd1);
      chk("alu_r_stall", 32'(stall), 32'd0);
      chk("alu_r_dsel", 32'(fwd_d_rs_sel), 32'd0);
      tick();
      set_idle();
      chk("alu_esel", 32'(fwd_e_rs_sel), 32'd1);
      tick(); tick();

      // ---------------- load-use ----------------
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2);
      chk("lu_ld_stall", 32'(stall), 32'd0);
      tick();
      set_d(5'd0, 2'd3, 5'd8, 2'd1, 5'd0, 2'd1);
      chk("lu_stall1", 32'(stall), 32'd1);
      tick();
      chk("lu_stall2", 32'(stall), 32'd0);
      tick();
      set_idle();
      chk("lu_esel", 32'(fwd_e_rt_sel), 32'd2);
      chk("lu_cnt", 32'(stall_cnt), 32'd1);
      tick(); tick();

      // ---------------- load -> beq ----------------
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd2);
      tick();
      set_d(5'd3, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1);
      chk("lb_stall1", 32'(stall), 32'd1);
      tick();
      chk("lb_stall2", 32'(stall), 32'd1);
      tick();
      chk("lb_stall3", 32'(stall), 32'd0);
      chk("lb_dsel", 32'(fwd_d_rs_sel), 32'd3);
      chk("lb_cnt", 32'(stall_cnt), 32'd3);
      tick();
      set_idle();
      tick(); tick();

      // ---------------- $0 never forwards or stalls ----------------
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2);
      tick();
      set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd1);
      chk("z_stall", 32'(stall), 32'd0);
      chk("z_dsel", 32'({fwd_d_rs_sel, fwd_d_rt_sel}), 32'd0);
      tick();
      set_idle();
      chk("z_esel", 32'({fwd_e_rs_sel, fwd_e_rt_sel}), 32'd0);
      tick(); tick();

      // ---------------- jal -> jr ----------------
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0);
      tick();
      set_d(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1);
      chk("jal_stall", 32'(stall), 32'd0);
      chk("jal_dsel", 32'(fwd_d_rs_sel), 32'd1);
      tick();
      set_idle();
      tick(); tick();

      // ---------------- load -> sw data ----------------
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd2);
      tick();
      set_d(5'd0, 2'd3, 5'd9, 2'd2, 5'd0, 2'd1);
      chk("sw_stall", 32'(stall), 32'd0);
      tick();
      set_idle();
      chk("sw_msel_e", 32'(fwd_m_rt_sel), 32'd0);
      tick();
      chk("sw_msel_m", 32'(fwd_m_rt_sel), 32'd1);
      tick(); tick();

      // ---------------- same register in E and M: E wins ----------------
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd1);
      tick();
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd4, 2'd0);
      tick();
      set_d(5'd4, 2'd1, 5'd4, 2'd0, 5'd0, 2'd1);
      chk("em_stall", 32'(stall), 32'd0);
      chk("em_dsel", 32'({fwd_d_rs_sel, fwd_d_rt_sel}), 32'h5);
      tick();
      set_idle();
      tick(); tick();

      // ---------------- same register in M and W: M wins ----------------
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd1);
      tick();
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 2'd1);
      tick();
      set_idle();
      tick();
      set_d(5'd6, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1);
      chk("mw_stall", 32'(stall), 32'd0);
      chk("mw_dsel", 32'(fwd_d_rs_sel), 32'd2);
      tick();
      set_idle();
      tick(); tick();

      // ---------------- reset asserted mid-stall ----------------
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd2);
      tick();
      set_d(5'd3, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1);
      chk("mr_stall_pre", 32'(stall), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr_stall_post", 32'(stall), 32'd0);
      chk("mr_cnt", 32'(stall_cnt), 32'd0);
      set_idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ---------------- stall counter saturation ----------------
      for (int i = 0; i < 3; i++) begin
         set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd2);
         tick();
         set_d(5'd3, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1);
         tick(); tick(); tick();
      end
      chk("sat_cnt6", 32'(stall_cnt), 32'd6);
      set_d(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd2);
      tick();
      set_d(5'd3, 2'd0, 5'd0, 2'd3, 5'd0, 2'd1);
      tick();
      chk("sat_cnt7", 32'(stall_cnt), 32'd7);
      chk("sat_stall", 32'(stall), 32'd1);
      tick();
      chk("sat_hold", 32'(stall_cnt), 32'd7);
      set_idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
